// File: rtl/instruction_decode_stage_pkg.sv
// instruction_decode_stage_pkg: opcodes, control-bit positions and opcode decode shared by the decode stage.
package instruction_decode_stage_pkg;

   localparam int DEFAULT_DATA_WIDTH     = 32;
   localparam int DEFAULT_REG_ADDR_WIDTH = 5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam int WB_REG_WRITE  = 0;
   localparam int WB_MEM_TO_REG = 1;
   localparam int MEM_WRITE     = 0;
   localparam int MEM_READ      = 1;
   localparam int MEM_BRANCH    = 2;
   localparam int EX_ALU_SRC    = 0;
   localparam int EX_REG_DST    = 1;
   localparam int EX_ALU_OP     = 2;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   typedef struct packed {
      logic [1:0] wb;
      logic [2:0] mem;
      logic [3:0] ex;
   } ctrl_t;

   function automatic ctrl_t decode_op(input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         OP_RTYPE: begin
            c.wb[WB_REG_WRITE]   = 1'b1;
            c.ex[EX_REG_DST]     = 1'b1;
            c.ex[EX_ALU_OP +: 2] = ALU_FUNCT;
         end
         OP_ADDI: begin
            c.wb[WB_REG_WRITE]   = 1'b1;
            c.ex[EX_ALU_SRC]     = 1'b1;
            c.ex[EX_ALU_OP +: 2] = ALU_ADD;
         end
         OP_LW: begin
            c.wb[WB_REG_WRITE]   = 1'b1;
            c.wb[WB_MEM_TO_REG]  = 1'b1;
            c.mem[MEM_READ]      = 1'b1;
            c.ex[EX_ALU_SRC]     = 1'b1;
            c.ex[EX_ALU_OP +: 2] = ALU_ADD;
         end
         OP_SW: begin
            c.mem[MEM_WRITE]     = 1'b1;
            c.ex[EX_ALU_SRC]     = 1'b1;
            c.ex[EX_ALU_OP +: 2] = ALU_ADD;
         end
         OP_BEQ: begin
            c.mem[MEM_BRANCH]    = 1'b1;
            c.ex[EX_ALU_OP +: 2] = ALU_SUB;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/instruction_decode_stage_hazard_unit.sv
// hazard_unit: load-use detection and the bubble counter that freezes PC and IF/ID.
module hazard_unit #(
   parameter int REG_ADDR_WIDTH  = 5,
   parameter int LOAD_USE_STALLS = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      if_id_valid,
   input  logic                      id_ex_valid,
   input  logic                      id_ex_mem_read,
   input  logic                      flush,
   input  logic [REG_ADDR_WIDTH-1:0] id_ex_rt,
   input  logic [REG_ADDR_WIDTH-1:0] if_id_rs,
   input  logic [REG_ADDR_WIDTH-1:0] if_id_rt,
   output logic                      bubble,
   output logic                      pc_write,
   output logic                      if_id_write
);

   logic [1:0] stall_count;
   logic       detect;

   assign detect = if_id_valid & id_ex_valid & id_ex_mem_read & (id_ex_rt != '0)
                 & ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt));
   assign bubble      = detect | (stall_count != 2'd0);
   assign pc_write    = ~bubble | flush;
   assign if_id_write = pc_write;

   // a running count masks new detects, so back-to-back hazards never overlap
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) stall_count <= 2'd0;
      else stall_count <= flush ? 2'd0
                        : (stall_count != 2'd0) ? stall_count - 2'd1
                        : detect ? 2'(LOAD_USE_STALLS - 1) : 2'd0;

endmodule

// File: rtl/instruction_decode_stage.sv
// instruction_decode_stage: register file with bypass, opcode decode, hazard stall and the ID/EX register.
module instruction_decode_stage
   import instruction_decode_stage_pkg::*;
#(
   parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
   parameter int REG_ADDR_WIDTH  = DEFAULT_REG_ADDR_WIDTH,
   parameter int LOAD_USE_STALLS = 1
) (
   input  logic                      clk,
   input  logic                      resetN,
   input  logic [DATA_WIDTH-1:0]     programCounterIn,
   input  logic [31:0]               instruction,
   input  logic                      ifIdValid,
   input  logic                      flush,
   input  logic [REG_ADDR_WIDTH-1:0] writeRegister,
   input  logic [DATA_WIDTH-1:0]     writeData,
   input  logic                      regWrite,
   output logic                      idExValid,
   output logic [1:0]                writeBackControl,
   output logic [2:0]                memAccessControl,
   output logic [3:0]                calculationControl,
   output logic [DATA_WIDTH-1:0]     programCounterOut,
   output logic [DATA_WIDTH-1:0]     readData1,
   output logic [DATA_WIDTH-1:0]     readData2,
   output logic [DATA_WIDTH-1:0]     immediateOperand,
   output logic [REG_ADDR_WIDTH-1:0] rs,
   output logic [REG_ADDR_WIDTH-1:0] rt,
   output logic [REG_ADDR_WIDTH-1:0] rd,
   output logic                      pcWrite,
   output logic                      ifIdWrite
);

   logic [DATA_WIDTH-1:0]     regs [2**REG_ADDR_WIDTH];
   logic [REG_ADDR_WIDTH-1:0] src_rs, src_rt, src_rd;
   logic [DATA_WIDTH-1:0]     rd1, rd2, imm;
   logic                      bubble, load_ctrl;
   ctrl_t                     ctrl;

   assign src_rs = REG_ADDR_WIDTH'(instruction[25:21]);
   assign src_rt = REG_ADDR_WIDTH'(instruction[20:16]);
   assign src_rd = REG_ADDR_WIDTH'(instruction[15:11]);
   assign imm    = {{(DATA_WIDTH-16){instruction[15]}}, instruction[15:0]};
   assign ctrl   = decode_op(instruction[31:26]);

   // r0 check comes first so a write to r0 can never be bypassed
   assign rd1 = (src_rs == '0) ? '0 : (regWrite && writeRegister == src_rs) ? writeData : regs[src_rs];
   assign rd2 = (src_rt == '0) ? '0 : (regWrite && writeRegister == src_rt) ? writeData : regs[src_rt];

   always_ff @(posedge clk or negedge resetN)
      if (!resetN) for (int i = 0; i < 2**REG_ADDR_WIDTH; i++) regs[i] <= '0;
      else if (regWrite && writeRegister != '0) regs[writeRegister] <= writeData;

   hazard_unit #(
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
      .LOAD_USE_STALLS(LOAD_USE_STALLS)
   ) u_hazard (
      .clk           (clk),
      .rst_n         (resetN),
      .if_id_valid   (ifIdValid),
      .id_ex_valid   (idExValid),
      .id_ex_mem_read(memAccessControl[MEM_READ]),
      .flush         (flush),
      .id_ex_rt      (rt),
      .if_id_rs      (src_rs),
      .if_id_rt      (src_rt),
      .bubble        (bubble),
      .pc_write      (pcWrite),
      .if_id_write   (ifIdWrite)
   );

   assign load_ctrl = ifIdValid & ~flush & ~bubble;

   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         idExValid          <= 1'b0;
         writeBackControl   <= '0;
         memAccessControl   <= '0;
         calculationControl <= '0;
         programCounterOut  <= '0;
         readData1          <= '0;
         readData2          <= '0;
         immediateOperand   <= '0;
         rs                 <= '0;
         rt                 <= '0;
         rd                 <= '0;
      end else begin
         idExValid <= load_ctrl;
         {writeBackControl, memAccessControl, calculationControl} <= load_ctrl ? ctrl : '0;
         programCounterOut <= programCounterIn;
         readData1         <= rd1;
         readData2         <= rd2;
         immediateOperand  <= imm;
         rs                <= src_rs;
         rt                <= src_rt;
         rd                <= src_rd;
      end

endmodule

// File: tb/tb_instruction_decode_stage.sv
// tb_instruction_decode_stage: directed checks of two decode stages (1 and 3 load-use bubbles) sharing one stimulus.
module tb_instruction_decode_stage;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          resetN, v, fl, we;
   logic [DW-1:0] pc, wd;
   logic [31:0]   instr;
   logic [AW-1:0] wr;

   logic          a_valid, a_pcw, a_ifw, b_valid, b_pcw, b_ifw;
   logic [1:0]    a_wb, b_wb;
   logic [2:0]    a_mem, b_mem;
   logic [3:0]    a_ex, b_ex;
   logic [DW-1:0] a_pc, a_rd1, a_rd2, a_imm, b_pc, b_rd1, b_rd2, b_imm;
   logic [AW-1:0] a_rs, a_rt, a_rd, b_rs, b_rt, b_rd;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instruction_decode_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .LOAD_USE_STALLS(1)) dut1 (
      .clk(clk), .resetN(resetN), .programCounterIn(pc), .instruction(instr), .ifIdValid(v),
      .flush(fl), .writeRegister(wr), .writeData(wd), .regWrite(we), .idExValid(a_valid),
      .writeBackControl(a_wb), .memAccessControl(a_mem), .calculationControl(a_ex),
      .programCounterOut(a_pc), .readData1(a_rd1), .readData2(a_rd2), .immediateOperand(a_imm),
      .rs(a_rs), .rt(a_rt), .rd(a_rd), .pcWrite(a_pcw), .ifIdWrite(a_ifw));

   instruction_decode_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .LOAD_USE_STALLS(3)) dut3 (
      .clk(clk), .resetN(resetN), .programCounterIn(pc), .instruction(instr), .ifIdValid(v),
      .flush(fl), .writeRegister(wr), .writeData(wd), .regWrite(we), .idExValid(b_valid),
      .writeBackControl(b_wb), .memAccessControl(b_mem), .calculationControl(b_ex),
      .programCounterOut(b_pc), .readData1(b_rd1), .readData2(b_rd2), .immediateOperand(b_imm),
      .rs(b_rs), .rt(b_rt), .rd(b_rd), .pcWrite(b_pcw), .ifIdWrite(b_ifw));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                      input logic [15:0] lo);
      return {op, s, t, lo};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      resetN = 1'b0; pc = '0; instr = '0; v = 1'b0; fl = 1'b0; we = 1'b0; wr = '0; wd = '0;
      tick(); tick();
      chk("rst_valid1", 64'(a_valid), 64'd0);
      chk("rst_valid3", 64'(b_valid), 64'd0);
      chk("rst_pcw1", 64'(a_pcw), 64'd1);
      chk("rst_ifw3", 64'(b_ifw), 64'd1);
      resetN = 1'b1;
      // bypass: write r5 while decoding add r3 = r5 + r0
      we = 1'b1; wr = 5'd5; wd = 32'hDEADBEEF; pc = 32'h100; v = 1'b1;
      instr = mk(6'h00, 5'd5, 5'd0, 16'h1800);
      tick();
      chk("byp_rd1_1", 64'(a_rd1), 64'hDEADBEEF);
      chk("byp_rd1_3", 64'(b_rd1), 64'hDEADBEEF);
      chk("add_valid", 64'(a_valid), 64'd1);
      chk("add_rd", 64'(a_rd), 64'd3);
      chk("add_wb", 64'(a_wb), 64'h1);
      chk("add_ex", 64'(a_ex), 64'hA);
      chk("add_mem", 64'(a_mem), 64'h0);
      chk("add_pc", 64'(a_pc), 64'h100);
      chk("add_imm", 64'(a_imm), 64'h1800);
      // write to r0 is ignored; addi r5 stored value read back, negative immediate
      wr = 5'd0; wd = 32'h12345678; pc = 32'h104;
      instr = mk(6'h08, 5'd0, 5'd5, 16'h8001);
      tick();
      chk("r0_byp", 64'(a_rd1), 64'd0);
      chk("r5_stored", 64'(a_rd2), 64'hDEADBEEF);
      chk("imm_neg", 64'(a_imm), 64'hFFFF8001);
      chk("addi_ex", 64'(a_ex), 64'h1);
      we = 1'b0;
      // lw r4; r0 still reads 0 after the attempted write
      pc = 32'h108; instr = mk(6'h23, 5'd0, 5'd4, 16'h7FFF);
      tick();
      chk("r0_stored", 64'(a_rd1), 64'd0);
      chk("lw_mem", 64'(a_mem), 64'h2);
      chk("lw_wb", 64'(a_wb), 64'h3);
      chk("imm_pos", 64'(a_imm), 64'h7FFF);
      chk("lw_rt", 64'(a_rt), 64'd4);
      // dependent add r6 = r4 + r1
      pc = 32'h10C; instr = mk(6'h00, 5'd4, 5'd1, 16'h3000);
      #1;
      chk("hz_pcw1", 64'(a_pcw), 64'd0);
      chk("hz_ifw1", 64'(a_ifw), 64'd0);
      chk("hz_pcw3", 64'(b_pcw), 64'd0);
      tick();
      chk("bub1_valid1", 64'(a_valid), 64'd0);
      chk("bub1_mem1", 64'(a_mem), 64'd0);
      chk("bub1_valid3", 64'(b_valid), 64'd0);
      chk("bub1_pcw1", 64'(a_pcw), 64'd1);
      chk("bub1_pcw3", 64'(b_pcw), 64'd0);
      tick();
      chk("dep_valid1", 64'(a_valid), 64'd1);
      chk("dep_rd1", 64'(a_rd), 64'd6);
      chk("bub2_valid3", 64'(b_valid), 64'd0);
      chk("bub2_pcw3", 64'(b_pcw), 64'd0);
      tick();
      chk("bub3_valid3", 64'(b_valid), 64'd0);
      chk("bub3_pcw3", 64'(b_pcw), 64'd1);
      tick();
      chk("dep_valid3", 64'(b_valid), 64'd1);
      chk("dep_rd3", 64'(b_rd), 64'd6);
      chk("dep_rs3", 64'(b_rs), 64'd4);
      // load to r0 never stalls
      instr = mk(6'h23, 5'd0, 5'd0, 16'h0);
      tick();
      instr = mk(6'h00, 5'd0, 5'd2, 16'h3800);
      #1;
      chk("r0ld_pcw1", 64'(a_pcw), 64'd1);
      chk("r0ld_pcw3", 64'(b_pcw), 64'd1);
      tick();
      chk("r0ld_valid3", 64'(b_valid), 64'd1);
      chk("r0ld_rd3", 64'(b_rd), 64'd7);
      // empty IF/ID gives an invalid ID/EX
      v = 1'b0;
      tick();
      chk("nv_valid", 64'(a_valid), 64'd0);
      chk("nv_wb", 64'(a_wb), 64'd0);
      v = 1'b1;
      // reset in the middle of a 3-bubble stall
      instr = mk(6'h23, 5'd0, 5'd7, 16'h0);
      tick();
      instr = mk(6'h00, 5'd7, 5'd7, 16'h4000);
      #1;
      chk("rs_hz_pcw3", 64'(b_pcw), 64'd0);
      tick();
      chk("rs_cnt2_pcw3", 64'(b_pcw), 64'd0);
      resetN = 1'b0;
      #1;
      chk("mrst_valid", 64'(b_valid), 64'd0);
      chk("mrst_pcw", 64'(b_pcw), 64'd1);
      chk("mrst_ifw", 64'(b_ifw), 64'd1);
      chk("mrst_pc", 64'(b_pc), 64'd0);
      chk("mrst_rt", 64'(b_rt), 64'd0);
      chk("mrst_rs", 64'(b_rs), 64'd0);
      tick();
      resetN = 1'b1;
      pc = 32'h200; instr = mk(6'h00, 5'd5, 5'd0, 16'h1800);
      tick();
      chk("post_valid3", 64'(b_valid), 64'd1);
      chk("post_rd3", 64'(b_rd), 64'd3);
      chk("post_r5_cleared", 64'(b_rd1), 64'd0);
      // flush while the 3-bubble counter is at 2
      instr = mk(6'h23, 5'd0, 5'd9, 16'h0);
      tick();
      instr = mk(6'h00, 5'd9, 5'd0, 16'h5000);
      tick();
      chk("fl_pre_pcw3", 64'(b_pcw), 64'd0);
      fl = 1'b1;
      #1;
      chk("fl_pcw3", 64'(b_pcw), 64'd1);
      chk("fl_ifw3", 64'(b_ifw), 64'd1);
      tick();
      chk("fl_valid3", 64'(b_valid), 64'd0);
      fl = 1'b0;
      #1;
      chk("fl_cleared_pcw3", 64'(b_pcw), 64'd1);
      tick();
      chk("fl_next_valid3", 64'(b_valid), 64'd1);
      chk("fl_next_rd3", 64'(b_rd), 64'd10);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
